maxpool_1d_fp: RTL and testbench
================================

# maxpool_1d_fp

Per-channel 1-D temporal max-pool stage that sits directly downstream of the batch-norm/ReLU stage. It consumes one NO_CH-wide vector per `vld_in` pulse and emits the element-wise maximum of every POOL consecutive valid vectors. Windows restart at each frame boundary of FRAME_LEN vectors, and a trailing partial window is flushed at frame end. Its output feeds the next convolution layer's window buffer.

## Interface
Parameters:
- NO_CH, 10, number of channels processed in parallel
- BW, 12, signed fixed-point word width per channel (same width as the upstream stage's output)
- POOL, 2, pooling window length in valid vectors; must be ≥ 1
- FRAME_LEN, 1024, valid vectors per frame; must be ≥ POOL

Ports:
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is asynchronous and active-low (rst = 0 resets)
- vld_in  in  1  data_in valid this cycle
- data_in  in  [NO_CH-1:0][BW-1:0]  input vector, each element signed two's complement
- vld_out  out  1  data_out valid, single-cycle pulse per window
- data_out  out  [NO_CH-1:0][BW-1:0]  pooled vector, signed
- frame_end  out  1  high with vld_out when the emitted window is the last of a frame

## Operation
- State: window counter `wcnt` (0..POOL-1), frame counter `fcnt` (0..FRAME_LEN-1), per-channel accumulator `acc[i]` (BW bits).
- All state changes only on cycles with vld_in = 1; with vld_in = 0, counters and acc hold, and vld_out/frame_end are 0 next cycle.
- On a valid cycle, define m[i] = data_in[i] if wcnt == 0, else signed max(acc[i], data_in[i]). Ties keep either value, since they are identical.
- Window close condition: wcnt == POOL-1 OR fcnt == FRAME_LEN-1.
  - On close: data_out <= m, vld_out <= 1, frame_end <= (fcnt == FRAME_LEN-1), wcnt <= 0.
  - Otherwise: acc <= m, wcnt <= wcnt+1.
- fcnt increments on every valid cycle. It wraps to 0 after FRAME_LEN-1; wcnt also forces to 0 at that point, so a partial window never spans a frame.
- Windows per frame = ceil(FRAME_LEN/POOL). The last window has FRAME_LEN mod POOL elements when that value is nonzero.
- Comparison is signed across the full BW. Although post-ReLU data is ≥ 0, the block does not rely on that.
- POOL = 1: every valid input is passed through with 1-cycle latency, and frame_end marks every FRAME_LEN-th output.
- data_out holds its last value between pulses and changes only on window close.

## Timing
- Reset (rst = 0, asynchronous): wcnt = 0, fcnt = 0, acc = 0, vld_out = 0, frame_end = 0, data_out = 0. These values apply immediately, without waiting for a clock edge.
- Reset release is synchronous in effect: the first valid sample accepted is on the first rising edge with rst = 1.
- Reset asserted mid-window: the partial window is discarded, no vld_out is produced for it, and the frame restarts at fcnt = 0.
- Latency: vld_out is asserted on the cycle after the clock edge that samples the window-closing vld_in (1-cycle registered latency).
- Throughput: vld_in may be high every cycle. Back-to-back windows produce vld_out pulses every POOL cycles with no bubbles.
- No backpressure: the downstream stage must accept vld_out whenever it is asserted.
- Gaps in vld_in are allowed anywhere inside a window and do not alter the result.

## Test plan
- Reset values: NO_CH=2, BW=12, POOL=2, FRAME_LEN=5. With rst=0, check vld_out=0, frame_end=0, data_out=0. Assert rst=0 with no clock running and check that outputs clear immediately.
- Basic pooling, same config: stream ch0 = 3,7,2,1,9 and ch1 = 5,4,0,8,6 with vld_in high continuously.
  - Required outputs: {7,5}, {2,8}, {9,6}.
  - vld_out pulses one cycle after inputs 2, 4 and 5.
  - frame_end is high only with {9,6}.
- Signed compare: send ch0 = -5 (0xFFB), then -2 (0xFFE) -> output -2. Send 0x7FF then 0x800 -> output 0x7FF.
- Gapped valid: same stream as the basic-pooling test, with vld_in low for 3 cycles between each sample -> identical output values, each pulse 1 cycle after its closing sample.
- Frame wrap: send 2 consecutive frames of 5 vectors -> 6 pulses total, with frame_end on pulses 3 and 6. Verify the second frame's first window does not include the first frame's 5th sample.
- Mid-window reset: send 1 sample (value 100), pulse rst low, then send 4,6 -> first output is 6 with no stale 100, and frame counting restarts at 0.

Source files
------------

// File: rtl/maxpool_1d_fp.sv
// maxpool_1d_fp: per-channel 1-D temporal max-pool over POOL consecutive valid
// vectors. Windows never span a frame of FRAME_LEN vectors; a trailing partial
// window is closed (and flagged with frame_end) on the last vector of a frame.
module maxpool_1d_fp #(
  parameter int unsigned NO_CH     = 10,
  parameter int unsigned BW        = 12,
  parameter int unsigned POOL      = 2,
  parameter int unsigned FRAME_LEN = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld_in,
  input  logic [NO_CH-1:0][BW-1:0]   data_in,
  output logic                       vld_out,
  output logic [NO_CH-1:0][BW-1:0]   data_out,
  output logic                       frame_end
);

  localparam int unsigned WCW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int unsigned FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(POOL - 1);
  localparam logic [FCW-1:0] FLAST = FCW'(FRAME_LEN - 1);

  logic [WCW-1:0]             wcnt;
  logic [FCW-1:0]             fcnt;
  logic [NO_CH-1:0][BW-1:0]   acc;
  logic [NO_CH-1:0][BW-1:0]   m;
  logic                       frm_last;
  logic                       win_close;

  // Running element-wise signed max; the first element of a window seeds it.
  always_comb begin
    m = '0;
    for (int i = 0; i < NO_CH; i++) begin
      if (wcnt == '0) begin
        m[i] = data_in[i];
      end else if ($signed(data_in[i]) > $signed(acc[i])) begin
        m[i] = data_in[i];
      end else begin
        m[i] = acc[i];
      end
    end
  end

  // Window closes on a full window or on the last vector of the frame.
  always_comb begin
    frm_last  = (fcnt == FLAST);
    win_close = (wcnt == WLAST) || frm_last;
  end

  // Counters, accumulator and registered outputs; everything holds without vld_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt      <= '0;
      fcnt      <= '0;
      acc       <= '0;
      vld_out   <= 1'b0;
      frame_end <= 1'b0;
      data_out  <= '0;
    end else begin
      vld_out   <= 1'b0;
      frame_end <= 1'b0;
      if (vld_in) begin
        fcnt <= frm_last ? '0 : fcnt + FCW'(1);
        if (win_close) begin
          data_out  <= m;
          vld_out   <= 1'b1;
          frame_end <= frm_last;
          wcnt      <= '0;
        end else begin
          acc  <= m;
          wcnt <= wcnt + WCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_1d_fp.sv
// Directed self-checking bench for maxpool_1d_fp (NO_CH=2, BW=12, POOL=2, FRAME_LEN=5).
module tb_maxpool_1d_fp;

  localparam int NO_CH     = 2;
  localparam int BW        = 12;
  localparam int POOL      = 2;
  localparam int FRAME_LEN = 5;

  logic                     clk    = 1'b0;
  logic                     clk_en = 1'b1;
  logic                     rst    = 1'b0;
  logic                     vld_in = 1'b0;
  logic [NO_CH-1:0][BW-1:0] data_in = '0;
  logic [NO_CH-1:0][BW-1:0] data_out;
  logic                     vld_out;
  logic                     frame_end;

  int n_vec = 0;
  int n_bad = 0;

  // Expected data_out: tracks the last pooled vector, zero after reset.
  logic [BW-1:0] hold0 = '0;
  logic [BW-1:0] hold1 = '0;

  maxpool_1d_fp #(
    .NO_CH    (NO_CH),
    .BW       (BW),
    .POOL     (POOL),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .vld_out  (vld_out),
    .data_out (data_out),
    .frame_end(frame_end)
  );

  always #5 if (clk_en) clk = ~clk;

  // Stimulus only: present inputs at a falling edge, advance to the next one.
  task automatic drive(input logic v, input int a, input int b);
    vld_in     = v;
    data_in[0] = BW'(a);
    data_in[1] = BW'(b);
    @(negedge clk);
  endtask

  // One-cycle low pulse on rst with vld_in idle.
  task automatic do_reset();
    vld_in = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    hold0 = '0;
    hold1 = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (vld_out !== 1'b0 || frame_end !== 1'b0 || data_out !== '0) begin
      n_bad++;
      $display("FAIL reset_held: got vld=%b fe=%b d=%h, want 0 0 0", vld_out, frame_end, data_out);
    end
    rst = 1'b1;
    drive(1'b1, 3, 5);
    drive(1'b1, 7, 4);
    n_vec++;
    if (vld_out !== 1'b1 || data_out[0] !== 12'd7 || data_out[1] !== 12'd5) begin
      n_bad++;
      $display("FAIL reset_prefill: got vld=%b d={%0d,%0d}, want 1 {7,5}",
               vld_out, data_out[0], data_out[1]);
    end
    // Freeze the clock, then assert reset: outputs must clear with no edge.
    clk_en = 1'b0;
    vld_in = 1'b0;
    #7;
    rst = 1'b0;
    #1;
    n_vec++;
    if (vld_out !== 1'b0 || frame_end !== 1'b0 || data_out !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got vld=%b fe=%b d=%h, want 0 0 0", vld_out, frame_end, data_out);
    end
    #5;
    rst    = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);
    hold0 = '0;
    hold1 = '0;
  endtask

  task automatic test_basic();
    int a0 [5] = '{3, 7, 2, 1, 9};
    int a1 [5] = '{5, 4, 0, 8, 6};
    int e0 [5] = '{0, 7, 0, 2, 9};
    int e1 [5] = '{0, 5, 0, 8, 6};
    bit ev [5] = '{0, 1, 0, 1, 1};
    bit fe [5] = '{0, 0, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, a0[k], a1[k]);
      if (ev[k]) begin
        hold0 = BW'(e0[k]);
        hold1 = BW'(e1[k]);
      end
      n_vec++;
      if (vld_out !== ev[k] || frame_end !== fe[k] || data_out[0] !== hold0 ||
          data_out[1] !== hold1) begin
        n_bad++;
        $display("FAIL basic[%0d]: got vld=%b fe=%b d={%0d,%0d}, want vld=%b fe=%b d={%0d,%0d}",
                 k, vld_out, frame_end, $signed(data_out[0]), $signed(data_out[1]),
                 ev[k], fe[k], $signed(hold0), $signed(hold1));
      end
    end
    drive(1'b0, 0, 0);
  endtask

  task automatic test_signed();
    int a0 [4] = '{-5, -2, 'h7FF, 'h800};
    int a1 [4] = '{-2048, 1, 0, -1};
    int e0 [4] = '{0, -2, 0, 'h7FF};
    int e1 [4] = '{0, 1, 0, 0};
    bit ev [4] = '{0, 1, 0, 1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, a0[k], a1[k]);
      if (ev[k]) begin
        hold0 = BW'(e0[k]);
        hold1 = BW'(e1[k]);
      end
      n_vec++;
      if (vld_out !== ev[k] || frame_end !== 1'b0 || data_out[0] !== hold0 ||
          data_out[1] !== hold1) begin
        n_bad++;
        $display("FAIL signed[%0d]: got vld=%b fe=%b d={%h,%h}, want vld=%b fe=0 d={%h,%h}",
                 k, vld_out, frame_end, data_out[0], data_out[1], ev[k], hold0, hold1);
      end
    end
    drive(1'b0, 0, 0);
  endtask

  task automatic test_gapped();
    int a0 [5] = '{3, 7, 2, 1, 9};
    int a1 [5] = '{5, 4, 0, 8, 6};
    int e0 [5] = '{0, 7, 0, 2, 9};
    int e1 [5] = '{0, 5, 0, 8, 6};
    bit ev [5] = '{0, 1, 0, 1, 1};
    bit fe [5] = '{0, 0, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, a0[k], a1[k]);
      if (ev[k]) begin
        hold0 = BW'(e0[k]);
        hold1 = BW'(e1[k]);
      end
      n_vec++;
      if (vld_out !== ev[k] || frame_end !== fe[k] || data_out[0] !== hold0 ||
          data_out[1] !== hold1) begin
        n_bad++;
        $display("FAIL gapped[%0d]: got vld=%b fe=%b d={%0d,%0d}, want vld=%b fe=%b d={%0d,%0d}",
                 k, vld_out, frame_end, data_out[0], data_out[1],
                 ev[k], fe[k], hold0, hold1);
      end
      for (int g = 0; g < 3; g++) begin
        drive(1'b0, 'hABC, 'h123);
        n_vec++;
        if (vld_out !== 1'b0 || frame_end !== 1'b0 || data_out[0] !== hold0 ||
            data_out[1] !== hold1) begin
          n_bad++;
          $display("FAIL gap_idle[%0d.%0d]: got vld=%b fe=%b d={%0d,%0d}, want 0 0 {%0d,%0d}",
                   k, g, vld_out, frame_end, data_out[0], data_out[1], hold0, hold1);
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    int a0 [10] = '{1, 2, 3, 4, 50, 1, 2, 3, 4, 5};
    int a1 [10] = '{9, 8, 7, 6, 5, 3, 1, 4, 1, 5};
    int e0 [10] = '{0, 2, 0, 4, 50, 0, 2, 0, 4, 5};
    int e1 [10] = '{0, 9, 0, 7, 5, 0, 3, 0, 4, 5};
    bit ev [10] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
    bit fe [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, a0[k], a1[k]);
      if (vld_out === 1'b1) pulses++;
      if (ev[k]) begin
        hold0 = BW'(e0[k]);
        hold1 = BW'(e1[k]);
      end
      n_vec++;
      if (vld_out !== ev[k] || frame_end !== fe[k] || data_out[0] !== hold0 ||
          data_out[1] !== hold1) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got vld=%b fe=%b d={%0d,%0d}, want vld=%b fe=%b d={%0d,%0d}",
                 k, vld_out, frame_end, data_out[0], data_out[1],
                 ev[k], fe[k], hold0, hold1);
      end
    end
    drive(1'b0, 0, 0);
    n_vec++;
    if (pulses != 6) begin
      n_bad++;
      $display("FAIL wrap_pulses: got %0d, want 6", pulses);
    end
  endtask

  task automatic test_mid_reset();
    int a0 [5] = '{4, 6, 1, 2, 7};
    int a1 [5] = '{5, 3, 0, 1, 0};
    int e0 [5] = '{0, 6, 0, 2, 7};
    int e1 [5] = '{0, 5, 0, 1, 0};
    bit ev [5] = '{0, 1, 0, 1, 1};
    bit fe [5] = '{0, 0, 0, 0, 1};
    do_reset();
    drive(1'b1, 100, 100);
    n_vec++;
    if (vld_out !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_open: got vld=%b, want 0", vld_out);
    end
    do_reset();
    n_vec++;
    if (vld_out !== 1'b0 || data_out !== '0) begin
      n_bad++;
      $display("FAIL midrst_clear: got vld=%b d=%h, want 0 0", vld_out, data_out);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, a0[k], a1[k]);
      if (ev[k]) begin
        hold0 = BW'(e0[k]);
        hold1 = BW'(e1[k]);
      end
      n_vec++;
      if (vld_out !== ev[k] || frame_end !== fe[k] || data_out[0] !== hold0 ||
          data_out[1] !== hold1) begin
        n_bad++;
        $display("FAIL midrst[%0d]: got vld=%b fe=%b d={%0d,%0d}, want vld=%b fe=%b d={%0d,%0d}",
                 k, vld_out, frame_end, data_out[0], data_out[1],
                 ev[k], fe[k], hold0, hold1);
      end
    end
    drive(1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_gapped();
    test_frame_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
